// File: rtl/riscv_configs.v
// Core-wide configuration: datapath width shared by pipeline blocks.
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V
`ifndef XLEN
`define XLEN 32
`endif
`endif

// File: rtl/riscv_register_memory.sv
// Execute-to-memory pipeline register with one skid slot: full-throughput
// valid/ready handshake, o_ready decoded from state only, synchronous flush.
`ifndef NOINC
`include "riscv_configs.v"
`endif
`ifndef XLEN
`define XLEN 32
`endif

module riscv_register_memory #(
  parameter logic [`XLEN-1:0] REGISTER_INIT = '0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [`XLEN-1:0] i_register_d_0,
  input  logic [`XLEN-1:0] i_register_d_1,
  input  logic [`XLEN-1:0] i_register_d_2,
  input  logic [`XLEN-1:0] i_register_d_3,
  input  logic [`XLEN-1:0] i_register_d_4,
  input  logic [`XLEN-1:0] i_register_d_5,
  input  logic [`XLEN-1:0] i_register_d_6,
  input  logic [`XLEN-1:0] i_register_d_7,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [`XLEN-1:0] o_register_q_0,
  output logic [`XLEN-1:0] o_register_q_1,
  output logic [`XLEN-1:0] o_register_q_2,
  output logic [`XLEN-1:0] o_register_q_3,
  output logic [`XLEN-1:0] o_register_q_4,
  output logic [`XLEN-1:0] o_register_q_5,
  output logic [`XLEN-1:0] o_register_q_6,
  output logic [`XLEN-1:0] o_register_q_7,
  input  logic             i_flush,
  output logic [1:0]       o_count
);

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  state_e                   state_q, state_d;
  logic [7:0][`XLEN-1:0]    main_q, main_d;
  logic [7:0][`XLEN-1:0]    skid_q, skid_d;
  logic [7:0][`XLEN-1:0]    data_in;
  logic                     up_xfer;
  logic                     dn_xfer;

  assign data_in = {i_register_d_7, i_register_d_6, i_register_d_5, i_register_d_4,
                    i_register_d_3, i_register_d_2, i_register_d_1, i_register_d_0};

  always_comb begin
    o_valid = 1'b0;
    o_ready = 1'b0;
    o_count = 2'd0;
    unique case (state_q)
      StEmpty: begin
        o_ready = 1'b1;
      end
      StBusy: begin
        o_valid = 1'b1;
        o_ready = 1'b1;
        o_count = 2'd1;
      end
      StFull: begin
        o_valid = 1'b1;
        o_count = 2'd2;
      end
      default: ;
    endcase
  end

  assign up_xfer = i_valid & o_ready;
  assign dn_xfer = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      // Flush wins over every transfer; data registers keep their contents.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (up_xfer) begin
            state_d = StBusy;
            main_d  = data_in;
          end
        end
        StBusy: begin
          if (up_xfer && dn_xfer) begin
            main_d = data_in;
          end else if (up_xfer) begin
            state_d = StFull;
            skid_d  = data_in;
          end else if (dn_xfer) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (dn_xfer) begin
            state_d = StBusy;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StEmpty;
      main_q  <= {8{REGISTER_INIT}};
      skid_q  <= {8{REGISTER_INIT}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign o_register_q_0 = main_q[0];
  assign o_register_q_1 = main_q[1];
  assign o_register_q_2 = main_q[2];
  assign o_register_q_3 = main_q[3];
  assign o_register_q_4 = main_q[4];
  assign o_register_q_5 = main_q[5];
  assign o_register_q_6 = main_q[6];
  assign o_register_q_7 = main_q[7];

endmodule

// File: tb/tb_riscv_register_memory.sv
// Bench for riscv_register_memory: directed scenarios plus a long random run
// checked against a bounded two-entry queue model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_register_memory;

  typedef logic [7:0][`XLEN-1:0] ws_t;

  localparam logic [`XLEN-1:0] Init = `XLEN'(32'hDEADBEEF);

  logic             i_clk;
  logic             i_rstn;
  logic             i_valid;
  logic             o_ready;
  logic             o_valid;
  logic             i_ready;
  logic             i_flush;
  logic [1:0]       o_count;
  ws_t              din;
  ws_t              obs;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: ordered queue of held word-sets, capacity two.
  ws_t mq[$];
  ws_t last_head;

  riscv_register_memory #(
    .REGISTER_INIT(Init)
  ) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_register_d_0(din[0]),
    .i_register_d_1(din[1]),
    .i_register_d_2(din[2]),
    .i_register_d_3(din[3]),
    .i_register_d_4(din[4]),
    .i_register_d_5(din[5]),
    .i_register_d_6(din[6]),
    .i_register_d_7(din[7]),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_register_q_0(obs[0]),
    .o_register_q_1(obs[1]),
    .o_register_q_2(obs[2]),
    .o_register_q_3(obs[3]),
    .o_register_q_4(obs[4]),
    .o_register_q_5(obs[5]),
    .o_register_q_6(obs[6]),
    .o_register_q_7(obs[7]),
    .i_flush       (i_flush),
    .o_count       (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic ws_t make_ws(input logic [`XLEN-1:0] base);
    ws_t w;
    for (int i = 0; i < 8; i++) w[i] = base + `XLEN'(i);
    return w;
  endfunction

  function automatic ws_t init_ws();
    ws_t w;
    for (int i = 0; i < 8; i++) w[i] = Init;
    return w;
  endfunction

  // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
  task automatic step(input logic v, input logic r, input logic f, input ws_t d);
    bit up;
    bit dn;
    i_valid = v;
    i_ready = r;
    i_flush = f;
    din     = d;
    up = v && (mq.size() < 2);
    dn = r && (mq.size() > 0);
    @(posedge i_clk);
    if (f) begin
      mq.delete();
    end else begin
      if (dn) void'(mq.pop_front());
      if (up) mq.push_back(d);
    end
    if (mq.size() > 0) last_head = mq[0];
    @(negedge i_clk);
  endtask

  task automatic apply_reset();
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    din     = '0;
    i_rstn  = 1'b0;
    mq.delete();
    last_head = init_ws();
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    #1;
    n_cmp++;
    if (o_valid !== 1'b0 || o_count !== 2'd0 || o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ctrl: valid=%b count=%0d ready=%b, required 0/0/1",
               o_valid, o_count, o_ready);
    end
    n_cmp++;
    if (obs !== init_ws()) begin
      n_err++;
      $display("FAIL reset_data: q0=%h q7=%h, required %h", obs[0], obs[7], Init);
    end
    apply_reset();
  endtask

  task automatic test_single();
    step(1'b1, 1'b1, 1'b0, make_ws(`XLEN'(1)));
    n_cmp++;
    if (o_valid !== 1'b1 || o_count !== 2'd1 || obs !== make_ws(`XLEN'(1))) begin
      n_err++;
      $display("FAIL single_out: valid=%b count=%0d q0=%h q7=%h, required 1/1/1/8",
               o_valid, o_count, obs[0], obs[7]);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    n_cmp++;
    if (o_valid !== 1'b0 || o_count !== 2'd0) begin
      n_err++;
      $display("FAIL single_drain: valid=%b count=%0d, required 0/0", o_valid, o_count);
    end
  endtask

  task automatic test_backpressure();
    ws_t a;
    ws_t b;
    a = make_ws(`XLEN'(32'hA0));
    b = make_ws(`XLEN'(32'hB0));
    step(1'b1, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 1'b0, b);
    n_cmp++;
    if (o_count !== 2'd2 || o_ready !== 1'b0 || obs !== a) begin
      n_err++;
      $display("FAIL bp_full: count=%0d ready=%b q0=%h, required 2/0/%h",
               o_count, o_ready, obs[0], a[0]);
    end
    step(1'b1, 1'b0, 1'b0, make_ws(`XLEN'(32'hC0)));
    n_cmp++;
    if (o_count !== 2'd2 || obs !== a) begin
      n_err++;
      $display("FAIL bp_stable: count=%0d q0=%h, required 2/%h", o_count, obs[0], a[0]);
    end
    i_ready = 1'b1;
    #1;
    n_cmp++;
    if (o_ready !== 1'b0 || obs !== a) begin
      n_err++;
      $display("FAIL bp_ready_path: ready=%b q0=%h, required 0/%h", o_ready, obs[0], a[0]);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    n_cmp++;
    if (o_valid !== 1'b1 || o_count !== 2'd1 || obs !== b) begin
      n_err++;
      $display("FAIL bp_second: valid=%b count=%0d q0=%h, required 1/1/%h",
               o_valid, o_count, obs[0], b[0]);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_count !== 2'd0) begin
      n_err++;
      $display("FAIL bp_empty: valid=%b ready=%b count=%0d, required 0/1/0",
               o_valid, o_ready, o_count);
    end
  endtask

  task automatic test_stream();
    int bad = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b1, 1'b0, make_ws(`XLEN'(k * 8 + 32'h100)));
      n_cmp++;
      if (o_valid !== 1'b1 || o_count !== 2'd1 || obs !== make_ws(`XLEN'(k * 8 + 32'h100))) begin
        n_err++;
        bad++;
        $display("FAIL stream_%0d: valid=%b count=%0d q0=%h, required 1/1/%h",
                 k, o_valid, o_count, obs[0], k * 8 + 32'h100);
      end
    end
    step(1'b0, 1'b1, 1'b0, '0);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_end: valid=%b, required 0 (earlier errors %0d)", o_valid, bad);
    end
  endtask

  task automatic test_flush();
    ws_t a;
    a = make_ws(`XLEN'(32'h200));
    step(1'b1, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 1'b0, make_ws(`XLEN'(32'h300)));
    step(1'b1, 1'b0, 1'b1, make_ws(`XLEN'(32'h400)));
    n_cmp++;
    if (o_valid !== 1'b0 || o_count !== 2'd0 || o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_ctrl: valid=%b count=%0d ready=%b, required 0/0/1",
               o_valid, o_count, o_ready);
    end
    n_cmp++;
    if (obs !== a) begin
      n_err++;
      $display("FAIL flush_hold: q0=%h, required %h", obs[0], a[0]);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      n_cmp++;
      if (o_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_leak_%0d: valid=%b q0=%h, required valid 0", k, o_valid, obs[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 1'b0, make_ws(`XLEN'(32'h500)));
    step(1'b1, 1'b0, 1'b0, make_ws(`XLEN'(32'h600)));
    step(1'b0, 1'b1, 1'b0, '0);
    #1;
    i_rstn = 1'b0;
    #1;
    n_cmp++;
    if (o_valid !== 1'b0 || o_count !== 2'd0 || o_ready !== 1'b1 || obs !== init_ws()) begin
      n_err++;
      $display("FAIL async_reset: valid=%b count=%0d ready=%b q0=%h, required 0/0/1/%h",
               o_valid, o_count, o_ready, obs[0], Init);
    end
    #1;
    i_rstn = 1'b1;
    mq.delete();
    last_head = init_ws();
    @(negedge i_clk);
    step(1'b0, 1'b1, 1'b0, '0);
    n_cmp++;
    if (o_valid !== 1'b0 || obs !== init_ws()) begin
      n_err++;
      $display("FAIL async_discard: valid=%b q0=%h, required 0/%h", o_valid, obs[0], Init);
    end
  endtask

  task automatic test_random();
    ws_t d;
    ws_t exp_q;
    for (int c = 0; c < 10000; c++) begin
      exp_q = (mq.size() > 0) ? mq[0] : last_head;
      n_cmp++;
      if (o_valid !== (mq.size() > 0) || o_ready !== (mq.size() < 2) ||
          o_count !== 2'(mq.size())) begin
        n_err++;
        $display("FAIL rand_ctrl_%0d: valid=%b ready=%b count=%0d, required count %0d",
                 c, o_valid, o_ready, o_count, mq.size());
      end
      n_cmp++;
      if (obs !== exp_q) begin
        n_err++;
        $display("FAIL rand_data_%0d: q0=%h q7=%h, required %h %h",
                 c, obs[0], obs[7], exp_q[0], exp_q[7]);
      end
      for (int i = 0; i < 8; i++) d[i] = `XLEN'($urandom);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 31) == 0), d);
    end
  endtask

  initial begin
    i_rstn  = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    din     = '0;
    last_head = init_ws();
    @(negedge i_clk);
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_register_memory.md
RISCV_REGISTER_MEMORY -- requirements
Module: riscv_register_memory

Interface
REQ-001 Parameter: REGISTER_INIT, default 0, value loaded into every data register on reset.
REQ-002 Data width: every data port SHALL be `XLEN bits wide, where `XLEN is taken from riscv_configs.v, included unless NOINC is defined.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rstn  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  upstream (execute side) word-set valid.
REQ-006 o_ready  output  1  block can accept an upstream word-set.
REQ-007 i_register_d_0..7  input  `XLEN each  upstream word-set, eight fields.
REQ-008 o_valid  output  1  downstream (memory side) word-set valid.
REQ-009 i_ready  input  1  downstream accepts the word-set.
REQ-010 o_register_q_0..7  output  `XLEN each  downstream word-set, registered.
REQ-011 i_flush  input  1  synchronous pipeline flush.
REQ-012 o_count  output  2  number of word-sets held, 0 to 2.

Function
REQ-013 An upstream transfer SHALL occur on a rising edge with i_valid=1 and o_ready=1. A downstream transfer SHALL occur on a rising edge with o_valid=1 and i_ready=1.
REQ-014 Storage SHALL consist of a main register set driving o_register_q_* and one skid register set of eight `XLEN fields.
REQ-015 States: EMPTY (o_count=0), BUSY (o_count=1), FULL (o_count=2). o_valid SHALL be 1 in BUSY and FULL. o_ready SHALL be 1 in EMPTY and BUSY, and SHALL be decoded from state only (no combinational path from i_ready).
REQ-016 EMPTY: upstream transfer -> BUSY, main<=inputs; otherwise stay.
REQ-017 BUSY: in and out together -> BUSY, main<=inputs. In only -> FULL, skid<=inputs, main held. Out only -> EMPTY. Neither -> hold.
REQ-018 FULL: no upstream transfer is possible. Out -> BUSY, main<=skid. Otherwise hold.
REQ-019 Latency SHALL be 1 cycle: a word-set accepted at edge N appears on o_register_q_* with o_valid=1 after edge N when the block was EMPTY, or when it was BUSY with a simultaneous downstream transfer.
REQ-020 Ordering SHALL be strictly FIFO. No word-set SHALL be dropped or duplicated except by flush.
REQ-021 While o_valid=1 and i_ready=0, o_register_q_* SHALL hold stable.
REQ-022 In EMPTY, o_register_q_* SHALL hold the last loaded values (or REGISTER_INIT), and o_valid=0.
REQ-023 i_flush=1 at an edge SHALL force EMPTY, with priority over all transfers. Any simultaneous upstream word-set SHALL be discarded. Data registers SHALL hold their values.
REQ-024 Sustained i_valid=1 and i_ready=1 SHALL give one word-set per cycle, with no bubbles.

Reset
REQ-025 While i_rstn=0, asynchronously: state=EMPTY, o_valid=0, o_count=0, o_ready=1, and all main and skid fields=REGISTER_INIT.
REQ-026 Reset asserted mid-operation SHALL discard all held word-sets. The first edge after deassertion SHALL behave as EMPTY.

Verification
REQ-027 Reset, then i_valid=1 with d_0..7=0x1..0x8 and i_ready=1 for one cycle -> next cycle o_valid=1, q_0..7=0x1..0x8, o_count=1; following cycle o_valid=0.
REQ-028 i_ready=0, push A=0xA0.. then B=0xB0.. -> o_count=2, o_ready=0, q=A stable. Raise i_ready -> q=A, then q=B, then o_valid=0, o_ready=1.
REQ-029 Streaming 16 incrementing word-sets with i_ready=1 -> 16 outputs in order, one per cycle, o_count never 2.
REQ-030 FULL with i_flush=1 and i_valid=1 on the same edge -> next cycle o_valid=0, o_count=0, o_ready=1, and the pushed word-set is never output.
REQ-031 BUSY, then i_rstn pulsed low between edges -> o_valid=0 and q=REGISTER_INIT immediately (checked with REGISTER_INIT=0xDEADBEEF).
REQ-032 Random i_valid/i_ready/i_flush for 10k cycles against a 2-deep FIFO scoreboard -> outputs match, and no handshake or stability violation occurs.
